// File: rtl/bidirectional_spi_responder_pkg.sv
// bidirectional_spi_pkg: shared types for the SPI responder.
// Frame FSM states and the R/W command bit encoding.
package bidirectional_spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WDATA,
        RDATA,
        WAIT_CS
    } rstate_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/bidirectional_spi_responder_if.sv
// bidirectional_spi_responder_if: register-bus bundle.
// master = the SPI responder, slave = the register file.
interface bidirectional_spi_responder_if #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 32
);

    logic [ADDR_WIDTH-1:0] reg_addr;
    logic                  reg_wr_en;
    logic [DATA_WIDTH-1:0] reg_wr_data;
    logic                  reg_rd_en;
    logic [DATA_WIDTH-1:0] reg_rd_data;

    modport master (
        output reg_addr,
        output reg_wr_en,
        output reg_wr_data,
        output reg_rd_en,
        input  reg_rd_data
    );

    modport slave (
        input  reg_addr,
        input  reg_wr_en,
        input  reg_wr_data,
        input  reg_rd_en,
        output reg_rd_data
    );

endinterface

// File: rtl/bidirectional_spi_responder_sync.sv
// spi_input_synchronizer: 2-flop sync for one SPI pin.
// A third flop holds the previous synced value for edge detect.
module spi_input_synchronizer (
    input  logic fabric_clk,
    input  logic reset_n,
    input  logic pin,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic meta;
    logic prev;

    // Metastability stages followed by the edge-history flop.
    always_ff @(posedge fabric_clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= pin;
            sync <= meta;
            prev <= sync;
        end
    end

    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/bidirectional_spi_responder.sv
// bidirectional_spi_responder: 3-wire SPI peripheral end.
// Decodes R/W + address + data frames onto a register bus.
module bidirectional_spi_responder
    import bidirectional_spi_pkg::*;
#(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 32
) (
    input  logic fabric_clk,
    input  logic reset_n,
    input  logic spi_cpol,
    input  logic spi_cpha,
    input  logic spi_sclk,
    input  logic spi_cs_n,
    inout  wire  spi_sdio,
    output logic sdio_oe,
    output logic busy,
    output logic frame_error,
    bidirectional_spi_responder_if.master reg_bus
);

    localparam int FRAME_BITS = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam int CW = $clog2(FRAME_BITS + 1);
    localparam logic [CW-1:0] CMD_LAST  = CW'(ADDR_WIDTH);
    localparam logic [CW-1:0] DATA_LAST = CW'(FRAME_BITS - 1);
    localparam logic [CW-1:0] CNT_SAT   = CW'(FRAME_BITS);

    rstate_t state_q;
    rstate_t state_d;

    logic [CW-1:0]         cnt_q;
    logic [ADDR_WIDTH-1:0] cmd_q;
    logic [DATA_WIDTH-1:0] dsr_q;
    logic                  sdo_q;
    logic                  rd_pend_q;

    logic sclk_s, sclk_rise, sclk_fall;
    logic cs_s, cs_rise, cs_fall;
    logic sdio_s, sdio_rise, sdio_fall;
    logic unused_sync;

    logic lead_edge, trail_edge;
    logic smp_edge, shf_edge;
    logic [ADDR_WIDTH:0] cmd_word;

    logic cnt_clr, cnt_inc;
    logic cmd_shift, dat_shift;
    logic cmd_done, wr_fire, err_fire, drive;

    spi_input_synchronizer u_sclk_sync (
        .fabric_clk (fabric_clk),
        .reset_n    (reset_n),
        .pin        (spi_sclk),
        .sync       (sclk_s),
        .rise       (sclk_rise),
        .fall       (sclk_fall)
    );

    spi_input_synchronizer u_cs_sync (
        .fabric_clk (fabric_clk),
        .reset_n    (reset_n),
        .pin        (spi_cs_n),
        .sync       (cs_s),
        .rise       (cs_rise),
        .fall       (cs_fall)
    );

    spi_input_synchronizer u_sdio_sync (
        .fabric_clk (fabric_clk),
        .reset_n    (reset_n),
        .pin        (spi_sdio),
        .sync       (sdio_s),
        .rise       (sdio_rise),
        .fall       (sdio_fall)
    );

    assign unused_sync = ^{sclk_s, cs_s, sdio_rise, sdio_fall};

    assign lead_edge  = spi_cpol ? sclk_fall : sclk_rise;
    assign trail_edge = spi_cpol ? sclk_rise : sclk_fall;
    assign smp_edge   = spi_cpha ? trail_edge : lead_edge;
    assign shf_edge   = spi_cpha ? lead_edge : trail_edge;

    assign cmd_word = {cmd_q, sdio_s};
    assign busy     = (state_q != IDLE);
    assign spi_sdio = sdio_oe ? sdo_q : 1'bz;

    // Frame state register.
    always_ff @(posedge fabric_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-cycle control strobes; CS release wins.
    always_comb begin
        state_d   = state_q;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        cmd_shift = 1'b0;
        dat_shift = 1'b0;
        cmd_done  = 1'b0;
        wr_fire   = 1'b0;
        err_fire  = 1'b0;
        drive     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d = CMD;
                    cnt_clr = 1'b1;
                end
            end
            CMD: begin
                if (cs_rise) begin
                    state_d  = IDLE;
                    err_fire = 1'b1;
                end else if (smp_edge) begin
                    cmd_shift = 1'b1;
                    cnt_inc   = 1'b1;
                    if (cnt_q == CMD_LAST) begin
                        cmd_done = 1'b1;
                        state_d  = (cmd_word[ADDR_WIDTH] == RW_READ)
                                 ? RDATA : WDATA;
                    end
                end
            end
            WDATA: begin
                if (cs_rise) begin
                    state_d  = IDLE;
                    err_fire = 1'b1;
                end else if (smp_edge) begin
                    dat_shift = 1'b1;
                    cnt_inc   = 1'b1;
                    if (cnt_q == DATA_LAST) begin
                        wr_fire = 1'b1;
                        state_d = WAIT_CS;
                    end
                end
            end
            RDATA: begin
                // With CPHA=1 no shift edge follows the final sample,
                // so the line is released on that sample instead.
                if (cs_rise) begin
                    state_d  = IDLE;
                    err_fire = 1'b1;
                end else if (smp_edge) begin
                    cnt_inc = 1'b1;
                    if (spi_cpha && cnt_q == DATA_LAST) begin
                        state_d = WAIT_CS;
                    end
                end else if (shf_edge) begin
                    if (cnt_q == CNT_SAT) begin
                        state_d = WAIT_CS;
                    end else begin
                        drive = 1'b1;
                    end
                end
            end
            WAIT_CS: begin
                if (cs_rise) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bit counter, shift registers, bus strobes and SDIO driver.
    always_ff @(posedge fabric_clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q               <= '0;
            cmd_q               <= '0;
            dsr_q               <= '0;
            sdo_q               <= 1'b0;
            sdio_oe             <= 1'b0;
            rd_pend_q           <= 1'b0;
            frame_error         <= 1'b0;
            reg_bus.reg_addr    <= '0;
            reg_bus.reg_wr_en   <= 1'b0;
            reg_bus.reg_wr_data <= '0;
            reg_bus.reg_rd_en   <= 1'b0;
        end else begin
            reg_bus.reg_wr_en <= wr_fire;
            reg_bus.reg_rd_en <= cmd_done
                              && (cmd_word[ADDR_WIDTH] == RW_READ);
            rd_pend_q   <= reg_bus.reg_rd_en;
            frame_error <= err_fire;
            if (cnt_clr) begin
                cnt_q <= '0;
            end else if (cnt_inc && cnt_q != CNT_SAT) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (cmd_shift) begin
                cmd_q <= cmd_word[ADDR_WIDTH-1:0];
            end
            if (cmd_done) begin
                reg_bus.reg_addr <= cmd_word[ADDR_WIDTH-1:0];
            end
            if (wr_fire) begin
                reg_bus.reg_wr_data <= {dsr_q[DATA_WIDTH-2:0], sdio_s};
            end
            if (dat_shift) begin
                dsr_q <= {dsr_q[DATA_WIDTH-2:0], sdio_s};
            end else if (rd_pend_q && state_q == RDATA) begin
                dsr_q <= reg_bus.reg_rd_data;
            end else if (drive) begin
                dsr_q <= {dsr_q[DATA_WIDTH-2:0], 1'b0};
            end
            if (drive) begin
                sdio_oe <= 1'b1;
                sdo_q   <= dsr_q[DATA_WIDTH-1];
            end else if (state_d != RDATA) begin
                sdio_oe <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bidirectional_spi_responder.sv
// tb_bidirectional_spi_responder: directed bench for the responder.
// Bit-banged SPI initiator plus a small register-file model.
module tb_bidirectional_spi_responder;

    logic fabric_clk = 1'b0;
    logic reset_n;
    logic spi_cpol;
    logic spi_cpha;
    logic spi_sclk;
    logic spi_cs_n;
    wire  spi_sdio;
    logic sdio_oe;
    logic busy;
    logic frame_error;

    logic tb_oe;
    logic tb_do;

    int n_cmp = 0;
    int n_err = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int err_cnt = 0;
    int hp = 4;

    logic [6:0]  wr_addr;
    logic [31:0] wr_data;
    logic [6:0]  rd_addr;
    logic [6:0]  rd_addr_q;
    logic        rd_pend_tb;
    logic        oe_seen;
    logic        oe_at_cs;
    logic [31:0] mem [128];

    bidirectional_spi_responder_if bus ();

    bidirectional_spi_responder dut (
        .fabric_clk  (fabric_clk),
        .reset_n     (reset_n),
        .spi_cpol    (spi_cpol),
        .spi_cpha    (spi_cpha),
        .spi_sclk    (spi_sclk),
        .spi_cs_n    (spi_cs_n),
        .spi_sdio    (spi_sdio),
        .sdio_oe     (sdio_oe),
        .busy        (busy),
        .frame_error (frame_error),
        .reg_bus     (bus)
    );

    assign spi_sdio = tb_oe ? tb_do : 1'bz;

    // Fabric clock, 10 time units per period.
    always #5 fabric_clk = ~fabric_clk;

    // Register-file model and pulse monitors, sampled mid-cycle.
    always @(negedge fabric_clk) begin
        bus.reg_rd_data = rd_pend_tb ? mem[rd_addr_q] : 32'h0;
        rd_pend_tb = bus.reg_rd_en;
        rd_addr_q  = bus.reg_addr;
        if (bus.reg_wr_en) begin
            wr_cnt++;
            wr_addr = bus.reg_addr;
            wr_data = bus.reg_wr_data;
            mem[bus.reg_addr] = bus.reg_wr_data;
        end
        if (bus.reg_rd_en) begin
            rd_cnt++;
            rd_addr = bus.reg_addr;
        end
        if (frame_error) err_cnt++;
        if (sdio_oe) oe_seen = 1'b1;
    end

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic put_bit(input logic [39:0] b,
                           input logic rw,
                           input int j);
        if (j < 40) begin
            if (rw && j >= 8) tb_oe = 1'b0;
            else tb_do = b[39-j];
        end
    endtask

    task automatic frame(input logic cpol,
                         input logic cpha,
                         input logic rw,
                         input logic [6:0] addr,
                         input logic [31:0] wd,
                         input int nbits,
                         input int extra,
                         input int rst_at,
                         input int gap,
                         output logic [31:0] rd);
        logic [39:0] bits;
        logic aborted;
        bits = {rw, addr, wd};
        rd = '0;
        aborted = 1'b0;
        spi_cpol = cpol;
        spi_cpha = cpha;
        spi_sclk = cpol;
        tb_oe = 1'b1;
        tb_do = 1'b0;
        repeat (hp) @(negedge fabric_clk);
        spi_cs_n = 1'b0;
        if (!cpha) tb_do = bits[39];
        repeat (hp) @(negedge fabric_clk);
        for (int i = 0; i < nbits + extra; i++) begin
            if (i == rst_at) begin
                chk("rst_pre_oe", sdio_oe, 1);
                #2 reset_n = 1'b0;
                #1;
                chk("rst_oe", sdio_oe, 0);
                chk("rst_busy", busy, 0);
                chk("rst_addr", bus.reg_addr, 0);
                aborted = 1'b1;
                break;
            end
            if (cpha) begin
                spi_sclk = ~spi_sclk;
                put_bit(bits, rw, i);
                repeat (hp) @(negedge fabric_clk);
                if (rw && i >= 8 && i < 40) rd = {rd[30:0], spi_sdio};
                spi_sclk = ~spi_sclk;
                repeat (hp) @(negedge fabric_clk);
            end else begin
                if (rw && i >= 8 && i < 40) rd = {rd[30:0], spi_sdio};
                spi_sclk = ~spi_sclk;
                repeat (hp) @(negedge fabric_clk);
                spi_sclk = ~spi_sclk;
                put_bit(bits, rw, i + 1);
                repeat (hp) @(negedge fabric_clk);
            end
        end
        repeat (hp) @(negedge fabric_clk);
        oe_at_cs = sdio_oe;
        spi_cs_n = 1'b1;
        tb_oe = 1'b1;
        spi_sclk = cpol;
        if (aborted) begin
            repeat (2) @(negedge fabric_clk);
            reset_n = 1'b1;
        end
        repeat (gap) @(negedge fabric_clk);
    endtask

    // Directed sequence: reset, six frame scenarios, summary.
    initial begin
        logic [31:0] rd;
        reset_n = 1'b0;
        spi_cpol = 1'b0;
        spi_cpha = 1'b0;
        spi_sclk = 1'b0;
        spi_cs_n = 1'b1;
        tb_oe = 1'b1;
        tb_do = 1'b0;
        rd_pend_tb = 1'b0;
        rd_addr_q = '0;
        oe_seen = 1'b0;
        oe_at_cs = 1'b0;
        bus.reg_rd_data = '0;
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        mem[7'h12] = 32'hA5A5_0F0F;
        mem[7'h7F] = 32'h3C5A_96E1;

        repeat (3) @(negedge fabric_clk);
        chk("reset_oe", sdio_oe, 0);
        chk("reset_busy", busy, 0);
        chk("reset_wr_en", bus.reg_wr_en, 0);
        chk("reset_rd_en", bus.reg_rd_en, 0);
        chk("reset_ferr", frame_error, 0);
        chk("reset_addr", bus.reg_addr, 0);
        chk("reset_wdata", bus.reg_wr_data, 0);
        reset_n = 1'b1;
        repeat (4) @(negedge fabric_clk);

        hp = 4;
        oe_seen = 1'b0;
        frame(0, 0, 0, 7'h05, 32'hDEAD_BEEF, 40, 0, -1, 4, rd);
        chk("m0w_wr_cnt", wr_cnt, 1);
        chk("m0w_addr", wr_addr, 7'h05);
        chk("m0w_data", wr_data, 32'hDEAD_BEEF);
        chk("m0w_oe_seen", oe_seen, 0);
        chk("m0w_ferr", err_cnt, 0);
        chk("m0w_busy", busy, 0);
        chk("m0w_reg_addr", bus.reg_addr, 7'h05);

        hp = 6;
        oe_seen = 1'b0;
        frame(1, 1, 1, 7'h12, 32'h0, 40, 0, -1, 4, rd);
        chk("m3r_rd_cnt", rd_cnt, 1);
        chk("m3r_addr", rd_addr, 7'h12);
        chk("m3r_data", rd, 32'hA5A5_0F0F);
        chk("m3r_oe_seen", oe_seen, 1);
        chk("m3r_oe_at_cs", oe_at_cs, 0);
        chk("m3r_ferr", err_cnt, 0);
        chk("m3r_wr_cnt", wr_cnt, 1);

        hp = 4;
        frame(0, 1, 0, 7'h33, 32'h1234_5678, 18, 0, -1, 8, rd);
        chk("m1a_ferr", err_cnt, 1);
        chk("m1a_wr_cnt", wr_cnt, 1);
        chk("m1a_busy", busy, 0);
        chk("m1a_mem", mem[7'h33], 32'h0);

        frame(1, 0, 0, 7'h01, 32'h0000_0001, 40, 0, -1, 4, rd);
        chk("m2_busy_gap", busy, 0);
        frame(1, 0, 1, 7'h01, 32'h0, 40, 0, -1, 4, rd);
        chk("m2_wr_cnt", wr_cnt, 2);
        chk("m2_wr_addr", wr_addr, 7'h01);
        chk("m2_wr_data", wr_data, 32'h0000_0001);
        chk("m2_rd_cnt", rd_cnt, 2);
        chk("m2_rd_addr", rd_addr, 7'h01);
        chk("m2_rd_data", rd, 32'h0000_0001);
        chk("m2_ferr", err_cnt, 1);

        frame(0, 0, 1, 7'h7F, 32'h0, 40, 0, 16, 4, rd);
        frame(0, 0, 1, 7'h7F, 32'h0, 40, 0, -1, 4, rd);
        chk("rst_rd_cnt", rd_cnt, 4);
        chk("rst_rd_addr", rd_addr, 7'h7F);
        chk("rst_rd_data", rd, 32'h3C5A_96E1);
        chk("rst_ferr", err_cnt, 1);

        oe_seen = 1'b0;
        frame(0, 0, 0, 7'h40, 32'h0BAD_F00D, 40, 40, -1, 4, rd);
        chk("xtra_wr_cnt", wr_cnt, 3);
        chk("xtra_wr_addr", wr_addr, 7'h40);
        chk("xtra_wr_data", wr_data, 32'h0BAD_F00D);
        chk("xtra_oe_seen", oe_seen, 0);
        chk("xtra_ferr", err_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
